// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared encodings, constants and helpers for the RV32M divide controller
package div_pkg;

  localparam logic [31:0] INT_MIN  = 32'h8000_0000;
  localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

  // bit 0 set means unsigned, bit 1 set means the remainder is returned
  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_RESP  = 3'd3,
    ST_DRAIN = 3'd4
  } div_state_e;

  function automatic logic op_is_signed(input logic [1:0] op);
    return !op[0];
  endfunction

  function automatic logic op_is_rem(input logic [1:0] op);
    return op[1];
  endfunction

  // two's-complement negation when neg is set; doubles as absolute value for negative inputs
  function automatic logic [31:0] cond_negate(input logic [31:0] x, input logic neg);
    return neg ? (32'd0 - x) : x;
  endfunction

endpackage

// File: rtl/div_sign_fix.sv
// rtl/div_sign_fix.sv - conditional negation of an operand pair (magnitudes in, signed results out)
module div_sign_fix
  import div_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        neg_a_i,
  input  logic        neg_b_i,
  output logic [31:0] a_o,
  output logic [31:0] b_o
);

  // each lane independently passes through or is negated
  always_comb begin
    a_o = cond_negate(a_i, neg_a_i);
    b_o = cond_negate(b_i, neg_b_i);
  end

endmodule

// File: rtl/div_ctrl32.sv
// rtl/div_ctrl32.sv - RV32M divide front end: special cases, sign handling, flush, result cache
module div_ctrl32
  import div_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int TAG_W    = 5,
  parameter bit CACHE_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             flush,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [XLEN-1:0]  req_rs1,
  input  logic [XLEN-1:0]  req_rs2,
  input  logic [TAG_W-1:0] req_tag,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [TAG_W-1:0] resp_tag,
  output logic             core_start,
  output logic [31:0]      core_dividend,
  output logic [31:0]      core_divisor,
  output logic             core_hold,
  input  logic             core_valid,
  input  logic [31:0]      core_q,
  input  logic [31:0]      core_rem
);

  div_state_e       state_q, state_d;
  logic [1:0]       op_q;
  logic [XLEN-1:0]  rs1_q, rs2_q;
  logic [TAG_W-1:0] tag_q;
  logic [31:0]      mag_a_q, mag_b_q;
  logic [XLEN-1:0]  res_quo_q, res_rem_q;

  logic             cache_vld_q;
  logic             cache_sgn_q;
  logic [XLEN-1:0]  cache_rs1_q, cache_rs2_q;
  logic [XLEN-1:0]  cache_quo_q, cache_rem_q;

  logic             accept;
  logic             req_signed;
  logic             sgn_q;
  logic             is_div0, is_ovf, is_hit, special;
  logic [XLEN-1:0]  spec_quo, spec_rem;
  logic [31:0]      mag_a, mag_b;
  logic [31:0]      fix_quo, fix_rem;

  assign req_signed = op_is_signed(req_op);
  assign sgn_q      = op_is_signed(op_q);
  assign accept     = req_valid && req_ready;

  // operand magnitudes handed to the unsigned core
  div_sign_fix u_pre (
    .a_i     (req_rs1),
    .b_i     (req_rs2),
    .neg_a_i (req_signed && req_rs1[XLEN-1]),
    .neg_b_i (req_signed && req_rs2[XLEN-1]),
    .a_o     (mag_a),
    .b_o     (mag_b)
  );

  // quotient takes the xor of operand signs, remainder follows the dividend
  div_sign_fix u_post (
    .a_i     (core_q),
    .b_i     (core_rem),
    .neg_a_i (sgn_q && (rs1_q[XLEN-1] ^ rs2_q[XLEN-1])),
    .neg_b_i (sgn_q && rs1_q[XLEN-1]),
    .a_o     (fix_quo),
    .b_o     (fix_rem)
  );

  // classify the incoming request; divide-by-zero beats overflow beats cache hit
  always_comb begin
    is_div0  = (req_rs2 == '0);
    is_ovf   = req_signed && (req_rs1 == INT_MIN) && (req_rs2 == ALL_ONES);
    is_hit   = CACHE_EN && cache_vld_q && (cache_rs1_q == req_rs1) &&
               (cache_rs2_q == req_rs2) && (cache_sgn_q == req_signed);
    special  = is_div0 || is_ovf || is_hit;
    spec_quo = cache_quo_q;
    spec_rem = cache_rem_q;
    if (is_div0) begin
      spec_quo = ALL_ONES;
      spec_rem = req_rs1;
    end else if (is_ovf) begin
      spec_quo = INT_MIN;
      spec_rem = '0;
    end
  end

  // state register
  always_ff @(posedge clk) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // next-state: a flush in WAIT must still absorb the core's completion in DRAIN
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (accept) state_d = special ? ST_RESP : ST_START;
      ST_START: state_d = flush ? ST_IDLE : ST_WAIT;
      ST_WAIT: begin
        if (core_valid)  state_d = flush ? ST_IDLE : ST_RESP;
        else if (flush)  state_d = ST_DRAIN;
      end
      ST_RESP:  if (flush || resp_ready) state_d = ST_IDLE;
      ST_DRAIN: if (core_valid) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // outputs decoded from state and registered datapath
  always_comb begin
    req_ready     = rstn && (state_q == ST_IDLE) && !flush;
    core_start    = (state_q == ST_START) && !flush;
    resp_valid    = (state_q == ST_RESP);
    resp_data     = op_is_rem(op_q) ? res_rem_q : res_quo_q;
    resp_tag      = tag_q;
    core_dividend = mag_a_q;
    core_divisor  = mag_b_q;
    core_hold     = 1'b0;
  end

  // request capture, result registers and the one-entry cache
  always_ff @(posedge clk) begin
    if (!rstn) begin
      op_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      tag_q       <= '0;
      mag_a_q     <= '0;
      mag_b_q     <= '0;
      res_quo_q   <= '0;
      res_rem_q   <= '0;
      cache_vld_q <= 1'b0;
      cache_sgn_q <= 1'b0;
      cache_rs1_q <= '0;
      cache_rs2_q <= '0;
      cache_quo_q <= '0;
      cache_rem_q <= '0;
    end else begin
      if (accept) begin
        op_q    <= req_op;
        rs1_q   <= req_rs1;
        rs2_q   <= req_rs2;
        tag_q   <= req_tag;
        mag_a_q <= mag_a;
        mag_b_q <= mag_b;
        if (special) begin
          res_quo_q <= spec_quo;
          res_rem_q <= spec_rem;
        end
      end
      if ((state_q == ST_WAIT) && core_valid) begin
        res_quo_q <= fix_quo;
        res_rem_q <= fix_rem;
      end
      if (((state_q == ST_WAIT) || (state_q == ST_DRAIN)) && core_valid) begin
        cache_vld_q <= 1'b1;
        cache_sgn_q <= sgn_q;
        cache_rs1_q <= rs1_q;
        cache_rs2_q <= rs2_q;
        cache_quo_q <= fix_quo;
        cache_rem_q <= fix_rem;
      end
    end
  end

endmodule

// File: tb/tb_div_ctrl32.sv
// tb/tb_div_ctrl32.sv - scoreboard bench for div_ctrl32 with a behavioural divider core
module tb_div_ctrl32;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [31:0] req_rs1 = '0;
  logic [31:0] req_rs2 = '0;
  logic [4:0]  req_tag = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_data;
  logic [4:0]  resp_tag;
  logic        core_start;
  logic [31:0] core_dividend, core_divisor;
  logic        core_hold;
  logic        core_valid = 1'b0;
  logic [31:0] core_q = '0;
  logic [31:0] core_rem = '0;

  div_ctrl32 #(.XLEN(32), .TAG_W(5), .CACHE_EN(1'b1)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_rs1(req_rs1), .req_rs2(req_rs2), .req_tag(req_tag),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_tag(resp_tag),
    .core_start(core_start), .core_dividend(core_dividend), .core_divisor(core_divisor),
    .core_hold(core_hold), .core_valid(core_valid), .core_q(core_q), .core_rem(core_rem)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  // architectural result from plain 64-bit arithmetic
  function automatic logic [31:0] ref_result(input logic [1:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint sa, sb, q, r;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'(a);
      sb = longint'(b);
    end
    q = sa / sb;
    r = sa % sb;
    return op[1] ? r[31:0] : q[31:0];
  endfunction

  typedef struct packed {
    logic [31:0] data;
    logic [4:0]  tag;
  } exp_t;
  exp_t sb[$];

  // behavioural divider core
  bit          core_busy = 1'b0;
  int          core_cnt = 0;
  int          lat_lo = 0, lat_hi = 6;
  int          nstarts = 0;
  logic [31:0] c_a = '0, c_b = '0;

  always @(negedge clk) begin
    if (!rstn) begin
      core_busy = 1'b0;
    end else begin
      if (core_busy && ((core_dividend !== c_a) || (core_divisor !== c_b))) begin
        chk_eq("core_operand_hold", core_dividend, c_a);
      end
      if (core_start) begin
        if (core_busy) fail_now("core_start_while_busy");
        core_busy = 1'b1;
        c_a = core_dividend;
        c_b = core_divisor;
        core_cnt = $urandom_range(lat_hi, lat_lo);
        nstarts++;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      core_valid = 1'b0;
      if (rstn && core_busy) begin
        if (core_cnt == 0) begin
          core_valid = 1'b1;
          core_q = (c_b == 0) ? 32'hFFFF_FFFF : c_a / c_b;
          core_rem = (c_b == 0) ? c_a : c_a % c_b;
          core_busy = 1'b0;
        end else begin
          core_cnt--;
        end
      end
    end
  end

  bit rr_random = 1'b0;
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rr_random) resp_ready = 1'($urandom_range(1, 0));
    end
  end

  // monitor: pop on handshake, and require held outputs while stalled
  logic        prev_v = 1'b0;
  logic        prev_end = 1'b0;
  logic [31:0] prev_d = '0;
  logic [4:0]  prev_t = '0;
  always @(negedge clk) begin
    exp_t e;
    if (!rstn) begin
      prev_v = 1'b0;
    end else begin
      if (prev_v && !prev_end) begin
        chk_eq("resp_valid_hold", 32'(resp_valid), 32'd1);
        chk_eq("resp_data_hold", resp_data, prev_d);
        chk_eq("resp_tag_hold", 32'(resp_tag), 32'(prev_t));
      end
      if (resp_valid && resp_ready && !flush) begin
        if (sb.size() == 0) begin
          fail_now($sformatf("unexpected_resp data=%h tag=%0d", resp_data, resp_tag));
        end else begin
          e = sb.pop_front();
          chk_eq("resp_data", resp_data, e.data);
          chk_eq("resp_tag", 32'(resp_tag), 32'(e.tag));
        end
      end
      prev_v = resp_valid;
      prev_d = resp_data;
      prev_t = resp_tag;
      prev_end = resp_ready || flush;
    end
  end

  // tasks are entered and left at posedge+1
  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag, input bit expect_resp);
    bit done = 1'b0;
    req_op = op;
    req_rs1 = a;
    req_rs2 = b;
    req_tag = tag;
    req_valid = 1'b1;
    for (int n = 0; n < 400 && !done; n++) begin
      @(negedge clk);
      if (req_ready) begin
        done = 1'b1;
        if (expect_resp) sb.push_back('{data: ref_result(op, a, b), tag: tag});
      end
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
    if (!done) fail_now("request_accept_timeout");
  endtask

  task automatic wait_empty();
    int n = 0;
    while (sb.size() != 0 && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      fail_now("response_timeout");
      sb.delete();
    end
  endtask

  task automatic expect_fast_resp(input string name);
    @(negedge clk);
    chk_eq(name, 32'(resp_valid), 32'd1);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(5, 0))
      0:       return 32'd0;
      1:       return INT_MIN;
      2:       return ALL_ONES;
      3:       return 32'($urandom_range(20, 0));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #900000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    bit seen;
    logic [31:0] la, lb, a, b;
    logic [1:0] op;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_eq("rst_req_ready", 32'(req_ready), 32'd0);
    chk_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk_eq("rst_resp_data", resp_data, 32'd0);
    chk_eq("rst_resp_tag", 32'(resp_tag), 32'd0);
    chk_eq("rst_core_start", 32'(core_start), 32'd0);
    chk_eq("rst_core_dividend", core_dividend, 32'd0);
    chk_eq("rst_core_divisor", core_divisor, 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    @(negedge clk);
    chk_eq("idle_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;

    // signed divide through the core, then remainder from the cache
    n0 = nstarts;
    send(OP_DIV, -32'sd7, 32'd2, 5'd1, 1'b1);
    wait_empty();
    chk_eq("div_core_starts", 32'(nstarts), 32'(n0 + 1));
    chk_eq("div_core_dividend", c_a, 32'd7);
    chk_eq("div_core_divisor", c_b, 32'd2);
    n0 = nstarts;
    send(OP_REM, -32'sd7, 32'd2, 5'd2, 1'b1);
    expect_fast_resp("rem_hit_latency");
    wait_empty();
    chk_eq("rem_hit_no_start", 32'(nstarts), 32'(n0));

    // divide by zero
    n0 = nstarts;
    send(OP_DIVU, 32'd100, 32'd0, 5'd3, 1'b1);
    expect_fast_resp("divu0_latency");
    wait_empty();
    send(OP_REMU, 32'd100, 32'd0, 5'd4, 1'b1);
    expect_fast_resp("remu0_latency");
    wait_empty();
    chk_eq("div0_no_start", 32'(nstarts), 32'(n0));

    // signed overflow
    send(OP_DIV, INT_MIN, ALL_ONES, 5'd5, 1'b1);
    expect_fast_resp("ovf_div_latency");
    wait_empty();
    send(OP_REM, INT_MIN, ALL_ONES, 5'd6, 1'b1);
    wait_empty();
    chk_eq("ovf_no_start", 32'(nstarts), 32'(n0));

    // stalled response stays stable; next accept only after handshake
    resp_ready = 1'b0;
    send(OP_REMU, ALL_ONES, 32'd3, 5'd9, 1'b1);
    seen = 1'b0;
    for (int n = 0; n < 100 && !seen; n++) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    if (!seen) fail_now("stall_resp_timeout");
    for (int i = 0; i < 5; i++) begin
      chk_eq("stall_req_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    resp_ready = 1'b1;
    @(negedge clk);
    chk_eq("hs_cycle_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk_eq("post_hs_req_ready", 32'(req_ready), 32'd1);
    chk_eq("post_hs_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1;
    wait_empty();

    // flush during WAIT: drain, no response, cache still loaded
    lat_lo = 10;
    lat_hi = 10;
    send(OP_DIVU, 32'd1000, 32'd7, 5'd10, 1'b0);
    @(negedge clk);
    chk_eq("flush_core_start", 32'(core_start), 32'd1);
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      @(negedge clk);
      chk_eq("drain_req_ready", 32'(req_ready), 32'd0);
      chk_eq("drain_resp_valid", 32'(resp_valid), 32'd0);
      if (core_valid) seen = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!seen) fail_now("drain_core_valid_timeout");
    @(negedge clk);
    chk_eq("after_drain_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    lat_lo = 0;
    lat_hi = 6;
    n0 = nstarts;
    send(OP_DIVU, 32'd1000, 32'd7, 5'd11, 1'b1);
    expect_fast_resp("drain_hit_latency");
    wait_empty();
    chk_eq("drain_hit_no_start", 32'(nstarts), 32'(n0));

    // flush beats req_valid in IDLE
    n0 = nstarts;
    req_op = OP_DIVU;
    req_rs1 = 32'd55;
    req_rs2 = 32'd9;
    req_tag = 5'd12;
    req_valid = 1'b1;
    flush = 1'b1;
    @(negedge clk);
    chk_eq("flush_idle_req_ready", 32'(req_ready), 32'd0);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    flush = 1'b0;
    @(negedge clk);
    chk_eq("flush_idle_ready_back", 32'(req_ready), 32'd1);
    chk_eq("flush_idle_no_resp", 32'(resp_valid), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    chk_eq("flush_idle_no_start", 32'(nstarts), 32'(n0));

    // randomized traffic with operand reuse to exercise the cache key
    rr_random = 1'b1;
    la = 32'd5;
    lb = 32'd3;
    for (int i = 0; i < 200; i++) begin
      op = 2'($urandom_range(3, 0));
      if ($urandom_range(9, 0) < 3) begin
        a = la;
        b = lb;
      end else begin
        a = pick();
        b = pick();
      end
      send(op, a, b, 5'(i), 1'b1);
      la = a;
      lb = b;
    end
    wait_empty();
    rr_random = 1'b0;
    resp_ready = 1'b1;
    repeat (4) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
